// File: rtl/dma_tlp_scheduler.sv
// Posted-write sequencer: streams fixed-size MWr TLPs from the ADC FIFO into a host ring
// buffer, raises half-buffer interrupts and limits DMA bursts while PIO completions wait.
module dma_tlp_scheduler #(
    parameter int TLP_DW     = 32,
    parameter int MAX_BURST  = 4,
    parameter int FIFO_CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dma_enable_i,
    input  logic                  cfg_bus_mstr_enable_i,
    input  logic [29:0]           buf_base_i,
    input  logic [15:0]           buf_tlps_i,
    input  logic [FIFO_CNT_W-1:0] fifo_count_i,
    input  logic                  req_compl_i,
    input  logic                  dma_rd_en_i,
    input  logic                  compl_done_i,
    output logic                  dma_start_o,
    output logic [29:0]           dma_addr_o,
    output logic                  half_irq_o,
    output logic                  half_sel_o,
    output logic [15:0]           wr_ptr_o,
    output logic [31:0]           tlp_count_o,
    output logic                  busy_o
);
    localparam int SHIFT = $clog2(TLP_DW);
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]         BURST_MAX = BW'(MAX_BURST);
    localparam logic [FIFO_CNT_W-1:0] FIFO_NEED = FIFO_CNT_W'(TLP_DW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DATA   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             en_q;
    logic [29:0]      base_q, base_d;
    logic [15:0]      tlps_q, tlps_d;
    logic [15:0]      ptr_q, ptr_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             start_q, start_d;
    logic [29:0]      addr_q, addr_d;
    logic             irq_q, irq_d;
    logic             sel_q, sel_d;
    logic [31:0]      count_q, count_d;
    logic             busy_q, busy_d;

    logic             capture_s;
    logic [29:0]      base_eff_s;
    logic [15:0]      tlps_eff_s;
    logic [15:0]      ptr_eff_s;
    logic [BW-1:0]    burst_eff_s;
    logic             go_s;
    logic             slot_lo_s;
    logic             slot_hi_s;

    function automatic logic [15:0] ring_next(input logic [15:0] ptr, input logic [15:0] len);
        logic [15:0] nxt;
        if (ptr == (len - 16'd1)) begin
            nxt = 16'd0;
        end else begin
            nxt = ptr + 16'd1;
        end
        return nxt;
    endfunction

    // A run-bit rising edge takes a fresh ring configuration; the *_eff values let an
    // issue in that same cycle already use it.
    assign capture_s   = dma_enable_i & ~en_q;
    assign base_eff_s  = capture_s ? buf_base_i : base_q;
    assign tlps_eff_s  = capture_s ? buf_tlps_i : tlps_q;
    assign ptr_eff_s   = capture_s ? 16'd0 : ptr_q;
    assign burst_eff_s = capture_s ? {BW{1'b0}} : burst_q;
    assign go_s        = dma_enable_i & cfg_bus_mstr_enable_i & (fifo_count_i >= FIFO_NEED)
                         & ~((burst_eff_s == BURST_MAX) & req_compl_i);
    assign slot_lo_s   = (ptr_q == ((tlps_q >> 1) - 16'd1));
    assign slot_hi_s   = (ptr_q == (tlps_q - 16'd1));

    // Next-state and registered-output logic of the TLP sequencer.
    always_comb begin
        state_d = state_q;
        base_d  = base_eff_s;
        tlps_d  = tlps_eff_s;
        ptr_d   = ptr_eff_s;
        burst_d = burst_eff_s;
        start_d = start_q;
        addr_d  = addr_q;
        irq_d   = 1'b0;
        sel_d   = sel_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (!req_compl_i) begin
                    burst_d = {BW{1'b0}};
                end else begin
                    burst_d = burst_eff_s;
                end
                if (go_s) begin
                    state_d = ST_ISSUE;
                    start_d = 1'b1;
                    addr_d  = base_eff_s + (30'(ptr_eff_s) << SHIFT);
                end else begin
                    start_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                // End-of-TLP pulses here belong to PIO completions.
                if (compl_done_i) begin
                    burst_d = {BW{1'b0}};
                end else begin
                    burst_d = burst_eff_s;
                end
                if (dma_rd_en_i) begin
                    state_d = ST_DATA;
                    start_d = 1'b0;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (compl_done_i) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                count_d = count_q + 32'd1;
                if (!capture_s) begin
                    ptr_d   = ring_next(ptr_q, tlps_q);
                    burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
                end else begin
                    ptr_d   = 16'd0;
                    burst_d = {BW{1'b0}};
                end
                if (slot_hi_s) begin
                    irq_d = 1'b1;
                    sel_d = 1'b1;
                end else if (slot_lo_s) begin
                    irq_d = 1'b1;
                    sel_d = 1'b0;
                end else begin
                    irq_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            base_q  <= 30'd0;
            tlps_q  <= 16'd0;
            ptr_q   <= 16'd0;
            burst_q <= {BW{1'b0}};
            start_q <= 1'b0;
            addr_q  <= 30'd0;
            irq_q   <= 1'b0;
            sel_q   <= 1'b0;
            count_q <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= dma_enable_i;
            base_q  <= base_d;
            tlps_q  <= tlps_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            irq_q   <= irq_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign dma_start_o = start_q;
    assign dma_addr_o  = addr_q;
    assign half_irq_o  = irq_q;
    assign half_sel_o  = sel_q;
    assign wr_ptr_o    = ptr_q;
    assign tlp_count_o = count_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/dma_tlp_scheduler.md
# dma_tlp_scheduler

Sequencer for the 32-bit PIO/DMA TX engine's posted memory-write path. It streams fixed-size MWr TLPs from the ADC data FIFO into a host ring buffer. For each TLP it checks FIFO occupancy and bus-master enable, raises `dma_start_o` with the target DW address, holds start until the engine accepts, and waits for the end of the TLP. It then advances a wrapping ring pointer, raises half-buffer interrupts, and bounds consecutive DMA TLPs so that PIO read completions are not starved.

## Interface
- `TLP_DW`, default 32: payload DWs per TLP; must equal the engine's `DMA_TLP_SIZE`; power of two, 1..512.
- `MAX_BURST`, default 4: consecutive DMA TLPs allowed while a completion request is pending.
- `FIFO_CNT_W`, default 11: width of the FIFO occupancy count.
- `clk` in 1: single clock, shared with the TX engine.
- `rst_n` in 1: asynchronous active-low reset.
- `dma_enable_i` in 1: software run bit.
- `cfg_bus_mstr_enable_i` in 1: PCIe bus-master enable.
- `buf_base_i` in 30: ring base, DW address [31:2].
- `buf_tlps_i` in 16: ring length in TLPs; even, ≥2.
- `fifo_count_i` in FIFO_CNT_W: DWs available in the data FIFO.
- `req_compl_i` in 1: PIO completion pending (from RX engine).
- `dma_rd_en_i` in 1: engine FIFO read enable, used as the acceptance indication.
- `compl_done_i` in 1: engine end-of-TLP pulse.
- `dma_start_o` out 1: request one MWr TLP.
- `dma_addr_o` out 30: DW address of the current TLP.
- `half_irq_o` out 1: one-cycle pulse when a ring half is filled.
- `half_sel_o` out 1: half just filled (0 = lower, 1 = upper).
- `wr_ptr_o` out 16: index of the next TLP slot.
- `tlp_count_o` out 32: total TLPs completed; wraps.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, ISSUE, DATA, UPDATE.
- Configuration capture:
  - On the rising edge of `dma_enable_i`, `buf_base_i` and `buf_tlps_i` are latched internally, and `wr_ptr` and the burst counter are cleared.
  - Input changes while enabled are ignored.
- IDLE → ISSUE requires all of:
  - `dma_enable_i`
  - `cfg_bus_mstr_enable_i`
  - `fifo_count_i ≥ TLP_DW`
  - not (`burst_cnt == MAX_BURST` and `req_compl_i`)
- On entry to ISSUE: `dma_start_o` goes to 1 and `dma_addr_o` = base_lat + wr_ptr·TLP_DW. The sum is mod 2^30 and computed by shift.
- ISSUE → DATA on the first cycle `dma_rd_en_i` = 1. `dma_start_o` drops in the same transition, so the engine is already in its data phase and cannot restart.
- `compl_done_i` pulses seen in ISSUE belong to PIO completions. They clear `burst_cnt` and do not change state.
- DATA → UPDATE on `compl_done_i` = 1.
- UPDATE, one cycle:
  - `tlp_count_o` += 1; `burst_cnt` += 1, saturating at MAX_BURST.
  - `wr_ptr` = (wr_ptr == buf_tlps−1) ? 0 : wr_ptr+1.
  - If the slot just written is buf_tlps/2−1: pulse `half_irq_o` with `half_sel_o` = 0.
  - If the slot just written is buf_tlps−1: pulse `half_irq_o` with `half_sel_o` = 1.
  - Next state is IDLE.
- `burst_cnt` clears in IDLE whenever `req_compl_i` = 0.
- Deasserting `dma_enable_i` or `cfg_bus_mstr_enable_i` is honoured only in IDLE. A TLP already in ISSUE, DATA or UPDATE runs to completion.

## Timing
- Reset values: `dma_start_o` 0, `dma_addr_o` 0, `half_irq_o` 0, `half_sel_o` 0, `wr_ptr_o` 0, `tlp_count_o` 0, `busy_o` 0; FSM in IDLE.
- Reset mid-TLP returns immediately to these values. The TX engine shares `rst_n`, so no TLP is left orphaned.
- All outputs are registered.
- Start latency: `dma_start_o` rises 1 cycle after the IDLE qualifying conditions are met.
- `dma_addr_o` is stable from ISSUE entry until UPDATE exits.
- Turnaround: the minimum gap from `compl_done_i` to the next `dma_start_o` is 2 cycles (UPDATE, then IDLE).
- `half_irq_o` is high for exactly the cycle after UPDATE. `half_sel_o` is valid in the same cycle and holds its value afterwards.
- Simultaneous `compl_done_i` and `dma_rd_en_i` in ISSUE: acceptance wins (go to DATA), and `burst_cnt` is still cleared.
- `fifo_count_i` is sampled only in IDLE; later drops are the FIFO's responsibility.

## Test plan
- Basic stream, buf_base=0x100, buf_tlps=4, TLP_DW=32, FIFO full:
  - `dma_addr_o` sequence is 0x100, 0x120, 0x140, 0x160, 0x100.
  - `half_irq_o` with sel=0 after the 2nd TLP and sel=1 after the 4th.
  - `tlp_count_o`=5.
- Starvation guard, MAX_BURST=4, `req_compl_i` held high:
  - Exactly 4 TLPs are issued, then `dma_start_o` stays 0.
  - After a completion `compl_done_i` and `req_compl_i`=0, issuing resumes.
- Gating:
  - `fifo_count_i`=31: no start.
  - Raising it to 32: start 1 cycle later.
  - `cfg_bus_mstr_enable_i`=0: no start regardless of FIFO.
- Enable drop during DATA: the TLP completes, the UPDATE increments are applied, and the FSM then idles with `dma_start_o`=0.
- Acceptance race: `compl_done_i` and `dma_rd_en_i` high in the same ISSUE cycle → DATA entered and `dma_start_o`=0 next cycle.
- Async reset asserted in DATA: all outputs 0 in the same cycle; re-enable restarts at buf_base with `wr_ptr`=0.
